// File: rtl/general_pack.sv
`default_nettype none
// ============================================================================
//  Module      : general_pack (package)
//  Description : Shared helpers and types for the Avalon-ST message blocks.
//                log2up_func : ceil(log2(value)), never less than 1, so that
//                              a 1-entry field still has a legal width.
//                arb_sm_t    : message arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package general_pack;

    function automatic int log2up_func(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_IN_MSG = 1'b1
    } arb_sm_t;

endpackage
`default_nettype wire

// File: rtl/avalon_st_if.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_st_if (interface)
//  Description : Avalon-ST style message stream with valid/rdy handshake.
//                master : drives valid, sop, eop, data, empty; samples rdy
//                slave  : samples valid, sop, eop, data, empty; drives rdy
//  Revision    : 1.0 - initial release
// ============================================================================
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    import general_pack::*;

    localparam int C_DATA_W  = DATA_WIDTH_IN_BYTES * 8;
    localparam int C_EMPTY_W = log2up_func(DATA_WIDTH_IN_BYTES);

    logic                 valid;
    logic                 rdy;
    logic                 sop;
    logic                 eop;
    logic [C_DATA_W-1:0]  data;
    logic [C_EMPTY_W-1:0] empty;

    modport master (output valid, sop, eop, data, empty, input  rdy);
    modport slave  (input  valid, sop, eop, data, empty, output rdy);

endinterface
`default_nettype wire

// File: rtl/avalon_msg_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_select
//  Description : Combinational round-robin picker. Returns the first set
//                request found searching upward from last_grant+1, wrapping
//                modulo NUM_REQ (last_grant itself is searched last).
//  Ports       : req        - request vector
//                last_grant - index granted most recently
//                sel_idx    - selected index (0 when nothing is requesting)
//                found      - at least one request was set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select
    import general_pack::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = log2up_func(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   sel_idx,
    output logic               found
);

    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Walk from the farthest offset to the nearest; the last hit written is
    // the nearest one, which is the highest priority.
    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[wrap_idx(int'(last_grant), k)]) begin
                sel_idx = wrap_idx(int'(last_grant), k);
                found   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/avalon_msg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_msg_arbiter
//  Description : Shares one Avalon-ST output among NUM_INPUTS requesters with
//                per-message round-robin arbitration. A message is granted on
//                its sop beat and held until its eop beat is accepted.
//                Zero latency: out_msg is a combinational mux of the selected
//                input. Stray beats (valid without sop) from non-selected
//                inputs are drained while idle.
//  Ports       : clk       - clock
//                rst       - asynchronous active-low reset
//                in_msg    - requester streams (slave side)
//                out_msg   - arbitrated stream (master side)
//                grant_idx - granted / selected input index
//                busy      - a message is in progress
//                drop_indi - per-input pulse when a stray beat is drained
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_msg_arbiter
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int NUM_INPUTS          = 4
)(
    input  logic                                 clk,
    input  logic                                 rst,
    avalon_st_if.slave                           in_msg [NUM_INPUTS],
    avalon_st_if.master                          out_msg,
    output logic [log2up_func(NUM_INPUTS)-1:0]   grant_idx,
    output logic                                 busy,
    output logic [NUM_INPUTS-1:0]                drop_indi
);

    localparam int C_IDX_W   = log2up_func(NUM_INPUTS);
    localparam int C_DATA_W  = DATA_WIDTH_IN_BYTES * 8;
    localparam int C_EMPTY_W = log2up_func(DATA_WIDTH_IN_BYTES);

    arb_sm_t              r_state;
    logic [C_IDX_W-1:0]   r_lock_idx;
    logic [C_IDX_W-1:0]   r_last_grant;
    logic                 r_rearb_gap;

    logic [NUM_INPUTS-1:0] w_in_valid;
    logic [NUM_INPUTS-1:0] w_in_sop;
    logic [NUM_INPUTS-1:0] w_in_eop;
    logic [NUM_INPUTS-1:0] w_in_rdy;
    logic [C_DATA_W-1:0]   w_in_data  [NUM_INPUTS];
    logic [C_EMPTY_W-1:0]  w_in_empty [NUM_INPUTS];

    logic [NUM_INPUTS-1:0] w_cand;
    logic [NUM_INPUTS-1:0] w_drop;
    logic [C_IDX_W-1:0]    w_sel_idx;
    logic                  w_found;
    logic [C_IDX_W-1:0]    w_idx;
    logic                  w_route;
    logic                  w_accept;

    logic                  w_out_valid;
    logic                  w_out_sop;
    logic                  w_out_eop;
    logic [C_DATA_W-1:0]   w_out_data;
    logic [C_EMPTY_W-1:0]  w_out_empty;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
        assign w_in_valid[gi] = in_msg[gi].valid;
        assign w_in_sop[gi]   = in_msg[gi].sop;
        assign w_in_eop[gi]   = in_msg[gi].eop;
        assign w_in_data[gi]  = in_msg[gi].data;
        assign w_in_empty[gi] = in_msg[gi].empty;
        assign in_msg[gi].rdy = w_in_rdy[gi];
    end

    // The cycle right after a multi-beat message closes is a re-arbitration
    // bubble: no new sop is offered, so messages are always separated.
    assign w_cand = (r_state == ARB_IDLE && !r_rearb_gap) ? (w_in_valid & w_in_sop)
                                                          : '0;

    rr_priority_select #(
        .NUM_REQ (NUM_INPUTS),
        .IDX_W   (C_IDX_W)
    ) u_rr_sel (
        .req        (w_cand),
        .last_grant (r_last_grant),
        .sel_idx    (w_sel_idx),
        .found      (w_found)
    );

    assign w_idx    = (r_state == ARB_IN_MSG) ? r_lock_idx : w_sel_idx;
    assign w_route  = (r_state == ARB_IN_MSG) || w_found;
    assign w_accept = w_route && w_in_valid[w_idx] && out_msg.rdy;

    // Outputs are forced quiet while reset is low so an abandoned message
    // stops immediately, not at the next clock.
    always_comb begin
        w_out_valid = 1'b0;
        w_out_sop   = 1'b0;
        w_out_eop   = 1'b0;
        w_out_data  = '0;
        w_out_empty = '0;
        w_in_rdy    = '0;
        w_drop      = '0;
        if (rst && w_route) begin
            w_out_valid     = w_in_valid[w_idx];
            w_out_sop       = w_in_sop[w_idx];
            w_out_eop       = w_in_eop[w_idx];
            w_out_data      = w_in_data[w_idx];
            w_out_empty     = w_in_empty[w_idx];
            w_in_rdy[w_idx] = out_msg.rdy;
        end
        // A selected input always carries sop, so the drain set never
        // overlaps the selection.
        if (rst && r_state == ARB_IDLE) begin
            w_drop   = w_in_valid & ~w_in_sop;
            w_in_rdy = w_in_rdy | w_drop;
        end
    end

    assign out_msg.valid = w_out_valid;
    assign out_msg.sop   = w_out_sop;
    assign out_msg.eop   = w_out_eop;
    assign out_msg.data  = w_out_data;
    assign out_msg.empty = w_out_empty;
    assign drop_indi     = w_drop;
    assign busy          = (r_state == ARB_IN_MSG);

    // With no candidate in idle, r_lock_idx still holds the last shown index.
    assign grant_idx = !rst                     ? '0
                     : (r_state == ARB_IN_MSG)  ? r_lock_idx
                     : w_found                  ? w_sel_idx
                     :                            r_lock_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ARB_IDLE;
            r_lock_idx   <= '0;
            r_last_grant <= C_IDX_W'(NUM_INPUTS - 1);
            r_rearb_gap  <= 1'b0;
        end else begin
            r_rearb_gap <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_lock_idx <= w_sel_idx;
                        if (w_accept) begin
                            r_last_grant <= w_sel_idx;
                            if (!w_in_eop[w_sel_idx]) begin
                                r_state <= ARB_IN_MSG;
                            end
                        end
                    end
                end
                ARB_IN_MSG: begin
                    if (w_accept && w_in_eop[r_lock_idx]) begin
                        r_state     <= ARB_IDLE;
                        r_rearb_gap <= 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
